// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control FSM:
// opcodes, state encoding, datapath select codes and the control bundle.
package rv_ctrl_pkg;

   // RV32I major opcodes handled by the controller
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // ALU operation class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Result / writeback select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_ALU_WB   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WB   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JAL_WB   = 4'd12,
      S_LUI      = 4'd13,
      S_ERROR    = 4'd14
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       ir_write;
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       reg_write;
   } ctrl_t;

endpackage

// File: rtl/rv_mem_wait_timer.sv
// Memory handshake watchdog: counts cycles spent waiting on mem_ready and
// flags expiry on the cycle whose wait would make the count reach TIMEOUT.
module rv_mem_wait_timer #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic wait_cyc,
   input  logic clr,
   output logic expire
);

   localparam logic             ENABLE = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Saturating increment so a disabled watchdog never wraps
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Wait counter: cleared on completion or state change, advanced while stalled
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (wait_cyc) begin
         cnt <= sat_inc(cnt);
      end
   end

   // A stalled cycle with TIMEOUT-1 waits already counted is the TIMEOUT-th wait
   assign expire = ENABLE && wait_cyc && (cnt == LAST);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I datapath. Sequences fetch, decode,
// execute, memory and writeback over a shared memory with a ready handshake,
// and raises sticky flags for illegal opcodes and memory timeouts.
module riscv_multicycle_ctrl #(
   parameter int OPCODE_W = 7,
   parameter int ALUOP_W  = 2,
   parameter int TIMEOUT  = 255,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                branch,
   output logic                ir_write,
   output logic                mem_req,
   output logic                mem_we,
   output logic                i_or_d,
   output logic [1:0]          alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [1:0]          result_src,
   output logic                reg_write,
   output logic                illegal,
   output logic                timeout
);

   import rv_ctrl_pkg::*;

   state_t     state;
   state_t     state_n;
   ctrl_t      c;
   logic [6:0] op;
   logic       dec_bad;
   logic       expire;
   logic       wait_cyc;
   logic       illegal_q;
   logic       timeout_q;

   assign op       = 7'(opcode);
   assign wait_cyc = c.mem_req & ~mem_ready;

   rv_mem_wait_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .wait_cyc (wait_cyc),
      .clr      (mem_ready | (state_n != state)),
      .expire   (expire)
   );

   // State register: reset abandons any access and restarts at FETCH
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_n;
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (dec_bad) illegal_q <= 1'b1;
         if (expire)  timeout_q <= 1'b1;
      end
   end

   // Next-state logic; a watchdog expiry overrides a stalled memory state
   always_comb begin
      state_n = state;
      dec_bad = 1'b0;
      case (state)
         S_FETCH:    if (mem_ready) state_n = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_R:               state_n = S_EXEC_R;
               OP_I_ALU:           state_n = S_EXEC_I;
               OP_LOAD, OP_STORE:  state_n = S_MEM_ADDR;
               OP_BRANCH:          state_n = S_BRANCH;
               OP_JAL:             state_n = S_JAL;
               OP_JALR:            state_n = S_JALR;
               OP_LUI:             state_n = S_LUI;
               default: begin
                  state_n = S_ERROR;
                  dec_bad = 1'b1;
               end
            endcase
         end
         S_EXEC_R, S_EXEC_I, S_LUI:  state_n = S_ALU_WB;
         S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JAL_WB:
                                     state_n = S_FETCH;
         S_MEM_ADDR: state_n = (op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) state_n = S_MEM_WB;
         S_MEM_WR:   if (mem_ready) state_n = S_FETCH;
         S_JALR:     state_n = S_JAL_WB;
         S_ERROR:    state_n = S_ERROR;
         default:    state_n = S_ERROR;
      endcase
      if (expire) state_n = S_ERROR;
   end

   // Output decode; everything is held low while rst is asserted so nothing
   // is requested before the state register has been initialised
   always_comb begin
      c = '0;
      case (state)
         S_FETCH: begin
            c.mem_req   = 1'b1;
            c.i_or_d    = 1'b0;
            c.alu_src_a = SRCA_PC;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALUOP_ADD;
            c.ir_write  = mem_ready;
            c.pc_write  = mem_ready;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXEC_I: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            c.reg_write  = 1'b1;
            c.result_src = RES_ALUOUT;
         end
         S_MEM_ADDR, S_LUI: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            c.mem_req = 1'b1;
            c.i_or_d  = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.result_src = RES_MEM;
         end
         S_MEM_WR: begin
            c.mem_req = 1'b1;
            c.mem_we  = 1'b1;
            c.i_or_d  = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a  = SRCA_RS1;
            c.alu_src_b  = SRCB_RS2;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
            c.branch     = 1'b1;
         end
         S_JAL: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALUOUT;
            c.pc_write   = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_JALR: begin
            c.alu_src_a  = SRCA_RS1;
            c.alu_src_b  = SRCB_IMM;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALU;
            c.pc_write   = 1'b1;
         end
         S_JAL_WB: begin
            // ALUOut now holds the jump target, so the link value oldPC+4
            // is recomputed here and written straight from the ALU result
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALU;
            c.reg_write  = 1'b1;
         end
         default: c = '0;
      endcase
      if (rst) c = '0;
   end

   assign pc_write   = c.pc_write;
   assign branch     = c.branch;
   assign ir_write   = c.ir_write;
   assign mem_req    = c.mem_req;
   assign mem_we     = c.mem_we;
   assign i_or_d     = c.i_or_d;
   assign alu_src_a  = c.alu_src_a;
   assign alu_src_b  = c.alu_src_b;
   assign alu_op     = ALUOP_W'(c.alu_op);
   assign result_src = c.result_src;
   assign reg_write  = c.reg_write;
   assign illegal    = illegal_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: random instruction streams
// with random handshake stalls, scored cycle by cycle against a per-class
// instruction script, plus directed illegal-opcode and timeout cases.
module tb_riscv_multicycle_ctrl;

   localparam int TO = 4;

   localparam logic [6:0] R_OP  = 7'b0110011;
   localparam logic [6:0] I_OP  = 7'b0010011;
   localparam logic [6:0] LD_OP = 7'b0000011;
   localparam logic [6:0] ST_OP = 7'b0100011;
   localparam logic [6:0] BR_OP = 7'b1100011;
   localparam logic [6:0] JL_OP = 7'b1101111;
   localparam logic [6:0] JR_OP = 7'b1100111;
   localparam logic [6:0] LU_OP = 7'b0110111;

   // {illegal,timeout | pc_write,branch,ir_write,mem_req,mem_we,i_or_d |
   //  src_a | src_b | alu_op | result_src | reg_write}
   localparam logic [16:0] V_ZERO  = 17'b0;
   localparam logic [16:0] V_FWAIT = {2'b00, 6'b000100, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] V_FDONE = {2'b00, 6'b101100, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] V_DEC   = {2'b00, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] V_EXR   = {2'b00, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
   localparam logic [16:0] V_EXI   = {2'b00, 6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
   localparam logic [16:0] V_AWB   = {2'b00, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
   localparam logic [16:0] V_MADDR = {2'b00, 6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] V_MRD   = {2'b00, 6'b000101, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] V_MWB   = {2'b00, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1};
   localparam logic [16:0] V_MWR   = {2'b00, 6'b000111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] V_BR    = {2'b00, 6'b010000, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
   localparam logic [16:0] V_JAL   = {2'b00, 6'b100000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b1};
   localparam logic [16:0] V_JALR  = {2'b00, 6'b100000, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
   localparam logic [16:0] V_JWB   = {2'b00, 6'b000000, 2'b01, 2'b10, 2'b00, 2'b10, 1'b1};
   localparam logic [16:0] V_LUI   = V_MADDR;
   localparam logic [16:0] V_ILL   = {2'b10, 15'b0};
   localparam logic [16:0] V_TO    = {2'b01, 15'b0};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_ready = 1'b0;
   logic [6:0] opcode = 7'b0;
   logic       pc_write, branch, ir_write, mem_req, mem_we, i_or_d, reg_write;
   logic       illegal, timeout;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic [16:0] obs;

   int n_total = 0;
   int n_bad   = 0;

   riscv_multicycle_ctrl #(
      .OPCODE_W (7),
      .ALUOP_W  (2),
      .TIMEOUT  (TO),
      .CNT_W    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .branch     (branch),
      .ir_write   (ir_write),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .i_or_d     (i_or_d),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .result_src (result_src),
      .reg_write  (reg_write),
      .illegal    (illegal),
      .timeout    (timeout)
   );

   assign obs = {illegal, timeout, pc_write, branch, ir_write, mem_req, mem_we, i_or_d,
                 alu_src_a, alu_src_b, alu_op, result_src, reg_write};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs just after a falling edge, check, move on
   task automatic step(input logic rdy, input logic [6:0] op, input logic [16:0] exp,
                       input string tag);
      mem_ready = rdy;
      opcode    = op;
      #1;
      chk(tag, obs, exp);
      @(negedge clk);
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [6:0] junk();
      return 7'($urandom);
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      #1 chk("reset_c1", obs, V_ZERO);
      @(negedge clk);
      #1 chk("reset_c2", obs, V_ZERO);
      rst = 1'b0;
   endtask

   task automatic fetch(input int fw);
      for (int i = 0; i < fw; i++) step(1'b0, junk(), V_FWAIT, "fetch_wait");
      step(1'b1, junk(), V_FDONE, "fetch_done");
   endtask

   // Expected cycle-by-cycle behaviour of one legal instruction
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
      fetch(fw);
      step(rnd_bit(), op, V_DEC, "decode");
      case (op)
         R_OP: begin
            step(rnd_bit(), op, V_EXR, "exec_r");
            step(rnd_bit(), op, V_AWB, "alu_wb_r");
         end
         I_OP: begin
            step(rnd_bit(), op, V_EXI, "exec_i");
            step(rnd_bit(), op, V_AWB, "alu_wb_i");
         end
         LU_OP: begin
            step(rnd_bit(), op, V_LUI, "lui");
            step(rnd_bit(), op, V_AWB, "alu_wb_lui");
         end
         LD_OP: begin
            step(rnd_bit(), op, V_MADDR, "maddr_ld");
            for (int i = 0; i < mw; i++) step(1'b0, op, V_MRD, "mem_rd_wait");
            step(1'b1, op, V_MRD, "mem_rd_done");
            step(rnd_bit(), op, V_MWB, "mem_wb");
         end
         ST_OP: begin
            step(rnd_bit(), op, V_MADDR, "maddr_st");
            for (int i = 0; i < mw; i++) step(1'b0, op, V_MWR, "mem_wr_wait");
            step(1'b1, op, V_MWR, "mem_wr_done");
         end
         BR_OP: step(rnd_bit(), op, V_BR, "branch");
         JL_OP: step(rnd_bit(), op, V_JAL, "jal");
         JR_OP: begin
            step(rnd_bit(), op, V_JALR, "jalr");
            step(rnd_bit(), op, V_JWB, "jal_wb");
         end
         default: chk("bench_bad_op", 17'b1, 17'b0);
      endcase
   endtask

   task automatic run_illegal(input logic [6:0] op);
      fetch(0);
      step(rnd_bit(), op, V_DEC, "decode_ill");
      for (int i = 0; i < 20; i++) step(rnd_bit(), junk(), V_ILL, "illegal_hold");
      do_reset();
   endtask

   logic [6:0] ops [8] = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JL_OP, JR_OP, LU_OP};

   initial begin
      do_reset();

      // Directed: one of each class with no stalls, then stall boundaries
      for (int k = 0; k < 8; k++) run_instr(ops[k], 0, 0);
      run_instr(LD_OP, 3, 3);
      run_instr(ST_OP, TO - 1, TO - 1);

      // Random instruction stream with random stalls below the limit
      for (int k = 0; k < 60; k++)
         run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, TO - 1),
                   $urandom_range(0, TO - 1));

      // Illegal opcodes: sticky until reset, then normal operation resumes
      run_illegal(7'b1111111);
      run_instr(R_OP, 0, 0);
      run_illegal(7'b0000000);

      // Fetch timeout: TO stalled cycles, then terminal ERROR
      for (int i = 0; i < TO; i++) step(1'b0, junk(), V_FWAIT, "fetch_stall");
      for (int i = 0; i < 6; i++) step(rnd_bit(), junk(), V_TO, "fetch_timeout");
      do_reset();

      // Ready on the last permissible cycle completes normally
      run_instr(I_OP, TO - 1, 0);

      // Load timeout in MEM_RD
      fetch(0);
      step(1'b0, LD_OP, V_DEC, "decode_ld_to");
      step(1'b0, LD_OP, V_MADDR, "maddr_ld_to");
      for (int i = 0; i < TO; i++) step(1'b0, LD_OP, V_MRD, "mem_rd_stall");
      for (int i = 0; i < 4; i++) step(rnd_bit(), junk(), V_TO, "mem_timeout");
      do_reset();
      run_instr(JL_OP, 1, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
